// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA peripheral blocks.
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SUB  = 2'd2
    } mm_state_t;

    // Width of a counter that has to reach width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/rsa_mont_step.sv
// One radix-2 Montgomery iteration: add the a partial product, make the sum even with n, halve.
module rsa_mont_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] n,
    input  logic             b_bit,
    output logic [WIDTH+1:0] acc_next
);

    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_red;

    // acc < 2n on entry keeps acc + a + n below 4*2^WIDTH, so WIDTH+2 bits never overflow.
    always_comb begin
        t_add    = acc + (b_bit ? {2'b00, a} : '0);
        t_red    = t_add + (t_add[0] ? {2'b00, n} : '0);
        acc_next = t_red >> 1;
    end

endmodule

// File: rtl/rsa_mont_mul.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod n, WIDTH iterations plus one subtract cycle.
//
//   state | meaning
//   IDLE  | waiting for start; done pulse (if any) is shown here
//   ITER  | one multiplier bit consumed per enabled cycle
//   SUB   | conditional final subtraction, loads result and raises done
module rsa_mont_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] I_LAST = CW'(WIDTH - 1);

    mm_state_t        state_q;
    mm_state_t        state_d;
    logic [WIDTH+1:0] acc_q;
    logic [WIDTH+1:0] acc_next;
    logic [CW-1:0]    i_cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res_d;

    // b_reg shifts right each iteration, so bit 0 is always the current multiplier bit.
    rsa_mont_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc_q),
        .a       (a_reg),
        .n       (n_reg),
        .b_bit   (b_reg[0]),
        .acc_next(acc_next)
    );

    // acc < 2n here, so acc - n fits in WIDTH bits whenever it is taken.
    always_comb begin
        diff  = acc_q[WIDTH-1:0] - n_reg;
        res_d = (acc_q >= {2'b00, n_reg}) ? diff : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ITER;
            ITER:    if (i_cnt == I_LAST) state_d = SUB;
            SUB:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            acc_q   <= '0;
            i_cnt   <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            n_reg   <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        n_reg <= n;
                        acc_q <= '0;
                        i_cnt <= '0;
                    end
                end
                ITER: begin
                    acc_q <= acc_next;
                    b_reg <= {1'b0, b_reg[WIDTH-1:1]};
                    i_cnt <= i_cnt + CW'(1);
                end
                SUB: begin
                    result <= res_d;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == ITER) || (state_q == SUB);

endmodule

// File: tb/tb_rsa_mont_mul.sv
// Scoreboard bench for rsa_mont_mul at WIDTH=8: expected results queued at start, checked at done.
module tb_rsa_mont_mul;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rstb  = 1'b0;
    logic         ena   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] n     = 8'd1;
    logic [W-1:0] result;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    rsa_mont_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .start (start),
        .a     (a),
        .b     (b),
        .n     (n),
        .result(result),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference by search: the unique x < n with x*2^W == a*b (mod n).
    function automatic logic [W-1:0] mont_ref(input int unsigned ta, input int unsigned tb,
                                              input int unsigned tn);
        int unsigned target;
        target = (ta * tb) % tn;
        for (int unsigned x = 0; x < tn; x++)
            if (((x << W) % tn) == target) return x[W-1:0];
        return '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge (must be called with the DUT in IDLE and ena=1).
    task automatic issue(input int unsigned ta, input int unsigned tb, input int unsigned tn);
        a = ta[W-1:0];
        b = tb[W-1:0];
        n = tn[W-1:0];
        start = 1'b1;
        exp_q.push_back(mont_ref(ta, tb, tn));
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 200) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        step();
        step();
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: result=%0d busy=%b done=%b, want 0/0/0", result, busy, done);
        end
        rstb = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int e;
        logic [W-1:0] exp;
        issue(5, 7, 13);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: busy=%b, want 1", busy);
        end
        wait_done(e);
        checks++;
        if (e != W + 1) begin
            failures++;
            $display("FAIL basic_latency: edges=%0d, want %0d", e, W + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_at_done: busy=%b, want 0", busy);
        end
        exp = exp_q.pop_front();
        checks++;
        if (result !== exp || result !== 8'd1) begin
            failures++;
            $display("FAIL basic_result: result=%0d, want %0d", result, exp);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_final_sub();
        int e;
        logic [W-1:0] exp;
        int unsigned vec[2][3] = '{'{12, 12, 13}, '{250, 250, 251}};
        for (int k = 0; k < 2; k++) begin
            issue(vec[k][0], vec[k][1], vec[k][2]);
            wait_done(e);
            exp = exp_q.pop_front();
            checks++;
            if (!done || result !== exp) begin
                failures++;
                $display("FAIL final_sub_%0d: done=%b result=%0d, want 1/%0d", k, done, result, exp);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int e;
        logic [W-1:0] exp;
        issue(0, 9, 13);
        wait_done(e);
        exp = exp_q.pop_front();
        checks++;
        if (!done || result !== exp) begin
            failures++;
            $display("FAIL zero_operand: done=%b result=%0d, want 1/%0d", done, result, exp);
        end
        issue(1, 5, 251);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
        end
        wait_done(e);
        checks++;
        if (e != W + 1) begin
            failures++;
            $display("FAIL b2b_latency: edges=%0d, want %0d", e, W + 1);
        end
        exp = exp_q.pop_front();
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL b2b_result: result=%0d, want %0d", result, exp);
        end
        step();
    endtask

    task automatic test_stall();
        bit [15:0] mask;
        int nst;
        int e;
        int overlap;
        int k;
        logic [W-1:0] exp;
        mask = '0;
        nst = 0;
        while (nst < 3) begin
            k = $urandom_range(3, 7);
            if (!mask[k]) begin
                mask[k] = 1'b1;
                nst++;
            end
        end
        issue(250, 250, 251);
        e = 0;
        overlap = 0;
        while (!done && e < 200) begin
            ena = !mask[e + 1];
            step();
            e++;
            if (done && busy) overlap++;
        end
        ena = 1'b1;
        checks++;
        if (e != W + 1 + 3) begin
            failures++;
            $display("FAIL stall_latency: edges=%0d, want %0d", e, W + 4);
        end
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL stall_busy_done_overlap: cycles=%0d, want 0", overlap);
        end
        exp = exp_q.pop_front();
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL stall_result: result=%0d, want %0d", result, exp);
        end
        ena = 1'b0;
        step();
        checks++;
        if (done !== 1'b1 || result !== exp) begin
            failures++;
            $display("FAIL stall_done_hold: done=%b result=%0d, want 1/%0d", done, result, exp);
        end
        ena = 1'b1;
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL stall_done_clear: done=%b, want 0", done);
        end
    endtask

    task automatic test_busy_protect();
        int e;
        int extra;
        logic [W-1:0] exp;
        issue(5, 7, 13);
        e = 0;
        while (!done && e < 200) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            n = W'($urandom_range(0, 127) * 2 + 1);
            start = 1'b1;
            step();
            e++;
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (e != W + 1 || result !== exp) begin
            failures++;
            $display("FAIL busy_protect: edges=%0d result=%0d, want %0d/%0d", e, result, W + 1, exp);
        end
        extra = 0;
        for (int c = 0; c < 2 * W; c++) begin
            step();
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL busy_protect_extra: active cycles=%0d, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        logic [W-1:0] exp;
        issue(250, 250, 251);
        repeat (4) step();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        void'(exp_q.pop_front());
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b result=%0d, want 0/0/0", busy, done, result);
        end
        e = 0;
        while (e < 2 * W) begin
            step();
            e++;
            if (done) break;
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done: done=%b after abort, want 0", done);
        end
        issue(12, 12, 13);
        wait_done(e);
        exp = exp_q.pop_front();
        checks++;
        if (e != W + 1 || result !== exp) begin
            failures++;
            $display("FAIL reset_mid_recover: edges=%0d result=%0d, want %0d/%0d", e, result, W + 1, exp);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_final_sub();
        test_back_to_back();
        test_stall();
        test_busy_protect();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_mont_mul.md
# rsa_mont_mul

Bit-serial Montgomery multiplier for the RSA peripheral. It computes R = A·B·2^-WIDTH mod N over WIDTH iterations plus one final-subtraction cycle. It sits directly upstream of the R_i holding shift register, which loads the `result` word when `done` pulses. Operands are latched on `start`. `result` stays stable until the next accepted `start`.

## Interface
- `WIDTH`, default 8: operand/modulus width in bits (≥ 2).

- `clk`  in  1: rising-edge clock
- `rstb`  in  1: reset, synchronous, active-low
- `ena`  in  1: clock enable; when 0, all state freezes
- `start`  in  1: request; sampled only in IDLE with `ena`=1
- `a`  in  WIDTH: multiplicand, must be < `n`
- `b`  in  WIDTH: multiplier, must be < `n`
- `n`  in  WIDTH: modulus, must be odd
- `result`  out  WIDTH: A·B·2^-WIDTH mod N, valid from `done` until next accepted `start`
- `busy`  out  1: high in ITER and SUB
- `done`  out  1: one-cycle pulse when `result` becomes valid

## Operation
- States: IDLE → ITER → SUB → IDLE.
- **IDLE**
  - `start`=1 & `ena`=1: latch a, b, n into internal registers.
  - Clear accumulator `acc` (WIDTH+2 bits) and bit counter `i`.
  - Go to ITER.
- **ITER**, per enabled cycle:
  - t = acc + (b_reg[i] ? a_reg : 0)
  - t = t + (t[0] ? n_reg : 0)
  - acc = t >> 1
  - i = i+1
  - After the iteration with i = WIDTH-1, go to SUB.
  - Intermediate values fit in WIDTH+2 bits. No truncation is permitted.
- **SUB**:
  - Invariant on entry: acc < 2·n_reg.
  - If acc ≥ n_reg, `result` = acc − n_reg; else `result` = acc[WIDTH-1:0].
  - Assert `done` for the next cycle and go to IDLE.
- `start` while busy: ignored, with no effect on operands or progress.
- `start` in the same cycle `done` is high: accepted, because the FSM is already in IDLE.
- `ena`=0 in any state:
  - Registers hold.
  - `done` holds its value. A pending pulse is extended until the next enabled cycle; it is then cleared.
- Even `n`, or operands ≥ `n`: `result` is unspecified. The FSM still completes in the same number of cycles. There is no error flag.
- Input changes on `a`/`b`/`n` after `start` is accepted have no effect.

## Timing
- Reset (`rstb`=0 at a rising edge):
  - State goes to IDLE.
  - `result`=0, `busy`=0, `done`=0; acc, i and operand registers are 0.
  - Reset overrides `ena`. Reset mid-operation aborts with no `done`.
- With `ena` held at 1, `start` sampled at edge E:
  - ITER updates occur at edges E+1 … E+WIDTH.
  - SUB occurs at edge E+WIDTH+1.
  - `done`=1 and `result` are valid during the cycle after edge E+WIDTH+1.
- Total latency is WIDTH+1 edges. Each low-`ena` cycle adds one cycle.
- `busy`=1 from after edge E until after edge E+WIDTH+1.
- `done` and `busy` are never high simultaneously.
- Back-to-back operation: a new `start` may be accepted on the edge that ends the `done` cycle.

## Structure
- Package `rsa_pkg` holds:
  - the state enum typedef `mm_state_t` (IDLE, ITER, SUB);
  - a function or localparam for counter width, $clog2(WIDTH).
  - Share it with the other RSA blocks.
- Sub-module `rsa_mont_step`:
  - combinational single iteration, (acc, a, n, b_bit) → acc_next;
  - parameterised by WIDTH;
  - instantiated once in the top.
- Top holds:
  - FSM;
  - counter;
  - operand registers (`b` may be a right-shifting register instead of indexed);
  - final subtractor;
  - output registers.

## Test plan
- Basic case, WIDTH=8: n=13, a=5, b=7, `start` → `done` after WIDTH+1 edges, `result`=1.
- Final-subtraction path: n=13, a=12, b=12 → `result`=3. Then n=251, a=250, b=250 → `result`=201 (0xC9).
- Zero operand: n=13, a=0, b=9 → `result`=0. Then repeat with `start` in the `done` cycle: n=251, a=1, b=5 → `result`=1 on back-to-back completion.
- Stall: run the n=251 case with `ena` low for 3 random cycles mid-ITER and 1 cycle during `done` → same `result`. `done` is extended by the stalled cycle; total latency is 9+3 edges.
- Busy protection: assert `start` with different operands every cycle while busy → first `result` unchanged, no extra `done`.
- Reset mid-operation: `rstb`=0 at iteration 4 → next cycle `busy`=0, `done`=0, `result`=0. A subsequent normal operation completes correctly.
